// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one memory port between instruction fetch (I) and data (D).
// Each access runs grant -> wait for mem_ready (bounded by TIMEOUT) -> one-cycle ack.
module mem_port_arbiter #(
   parameter int ADDR_W  = 64,
   parameter int DATA_W  = 64,
   parameter int TIMEOUT = 15
) (
   input  logic              clock,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic              i_ack,
   output logic [DATA_W-1:0] i_rdata,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [1:0]        d_size,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic              d_ack,
   output logic [DATA_W-1:0] d_rdata,
   output logic              mem_req,
   output logic              mem_we,
   output logic [1:0]        mem_size,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic              mem_ready,
   input  logic [DATA_W-1:0] mem_rdata,
   output logic              bus_err,
   output logic              owner
);

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   localparam logic [7:0] TIMEOUT_C = 8'(TIMEOUT);
   localparam logic [7:0] CNT_MAX   = 8'hFF;
   localparam logic [1:0] I_SIZE    = 2'b10;

   state_t              state_q, state_d;
   logic                owner_q, owner_d;
   logic [7:0]          cnt_q, cnt_d;
   logic                mem_req_q, mem_req_d;
   logic                mem_we_q, mem_we_d;
   logic [1:0]          mem_size_q, mem_size_d;
   logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
   logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
   logic                i_ack_q, i_ack_d;
   logic                d_ack_q, d_ack_d;
   logic                bus_err_q, bus_err_d;
   logic [DATA_W-1:0]   i_rdata_q, i_rdata_d;
   logic [DATA_W-1:0]   d_rdata_q, d_rdata_d;
   logic                grant_d_s;
   logic                timeout_s;

   // Arbitration: a lone request wins; on collision the port that is not owner wins.
   always_comb begin
      if (i_req && d_req) begin
         grant_d_s = ~owner_q;
      end else if (d_req) begin
         grant_d_s = 1'b1;
      end else begin
         grant_d_s = 1'b0;
      end
   end

   // Timeout detection once the wait counter has reached its limit.
   always_comb begin
      if (cnt_q >= TIMEOUT_C) begin
         timeout_s = 1'b1;
      end else begin
         timeout_s = 1'b0;
      end
   end

   // Next-state and registered-output computation for the access sequencer.
   always_comb begin
      state_d     = state_q;
      owner_d     = owner_q;
      cnt_d       = cnt_q;
      mem_req_d   = mem_req_q;
      mem_we_d    = mem_we_q;
      mem_size_d  = mem_size_q;
      mem_addr_d  = mem_addr_q;
      mem_wdata_d = mem_wdata_q;
      i_rdata_d   = i_rdata_q;
      d_rdata_d   = d_rdata_q;
      i_ack_d     = 1'b0;
      d_ack_d     = 1'b0;
      bus_err_d   = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (i_req || d_req) begin
               owner_d   = grant_d_s;
               cnt_d     = 8'd0;
               mem_req_d = 1'b1;
               state_d   = ST_ACCESS;
               if (grant_d_s) begin
                  mem_we_d    = d_we;
                  mem_size_d  = d_size;
                  mem_addr_d  = d_addr;
                  mem_wdata_d = d_wdata;
               end else begin
                  mem_we_d    = 1'b0;
                  mem_size_d  = I_SIZE;
                  mem_addr_d  = i_addr;
                  mem_wdata_d = {DATA_W{1'b0}};
               end
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_ACCESS: begin
            if (mem_ready) begin
               mem_req_d = 1'b0;
               state_d   = ST_RESP;
               if (owner_q) begin
                  d_rdata_d = mem_rdata;
                  d_ack_d   = 1'b1;
               end else begin
                  i_rdata_d = mem_rdata;
                  i_ack_d   = 1'b1;
               end
            end else if (timeout_s) begin
               // Timed-out access still completes with an ack so the requester never hangs.
               mem_req_d = 1'b0;
               bus_err_d = 1'b1;
               state_d   = ST_RESP;
               if (owner_q) begin
                  d_rdata_d = {DATA_W{1'b0}};
                  d_ack_d   = 1'b1;
               end else begin
                  i_rdata_d = {DATA_W{1'b0}};
                  i_ack_d   = 1'b1;
               end
            end else begin
               if (cnt_q != CNT_MAX) begin
                  cnt_d = cnt_q + 8'd1;
               end else begin
                  cnt_d = cnt_q;
               end
            end
         end

         ST_RESP: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end

         default: begin
            state_d   = ST_IDLE;
            mem_req_d = 1'b0;
         end
      endcase
   end

   // State and output registers; reset clears everything immediately.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q     <= ST_IDLE;
         owner_q     <= 1'b0;
         cnt_q       <= 8'd0;
         mem_req_q   <= 1'b0;
         mem_we_q    <= 1'b0;
         mem_size_q  <= 2'b00;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_wdata_q <= {DATA_W{1'b0}};
         i_rdata_q   <= {DATA_W{1'b0}};
         d_rdata_q   <= {DATA_W{1'b0}};
         i_ack_q     <= 1'b0;
         d_ack_q     <= 1'b0;
         bus_err_q   <= 1'b0;
      end else begin
         state_q     <= state_d;
         owner_q     <= owner_d;
         cnt_q       <= cnt_d;
         mem_req_q   <= mem_req_d;
         mem_we_q    <= mem_we_d;
         mem_size_q  <= mem_size_d;
         mem_addr_q  <= mem_addr_d;
         mem_wdata_q <= mem_wdata_d;
         i_rdata_q   <= i_rdata_d;
         d_rdata_q   <= d_rdata_d;
         i_ack_q     <= i_ack_d;
         d_ack_q     <= d_ack_d;
         bus_err_q   <= bus_err_d;
      end
   end

   assign owner     = owner_q;
   assign mem_req   = mem_req_q;
   assign mem_we    = mem_we_q;
   assign mem_size  = mem_size_q;
   assign mem_addr  = mem_addr_q;
   assign mem_wdata = mem_wdata_q;
   assign i_ack     = i_ack_q;
   assign d_ack     = d_ack_q;
   assign i_rdata   = i_rdata_q;
   assign d_rdata   = d_rdata_q;
   assign bus_err   = bus_err_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard bench for mem_port_arbiter: a grant monitor predicts the winner and response,
// a memory model inserts wait states, and an ack monitor checks every response.
module tb_mem_port_arbiter;

   localparam int TO = 15;

   logic        clock, reset;
   logic        i_req, d_req, d_we, mem_ready;
   logic [63:0] i_addr, d_addr, d_wdata, mem_rdata;
   logic [1:0]  d_size;
   logic        i_ack, d_ack, mem_req, mem_we, bus_err, owner;
   logic [63:0] i_rdata, d_rdata, mem_addr, mem_wdata;
   logic [1:0]  mem_size;

   mem_port_arbiter #(.ADDR_W(64), .DATA_W(64), .TIMEOUT(TO)) dut (
      .clock(clock), .reset(reset),
      .i_req(i_req), .i_addr(i_addr), .i_ack(i_ack), .i_rdata(i_rdata),
      .d_req(d_req), .d_we(d_we), .d_size(d_size), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_req(mem_req), .mem_we(mem_we), .mem_size(mem_size), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata),
      .bus_err(bus_err), .owner(owner)
   );

   typedef struct {
      bit          port;
      logic [63:0] rdata;
      bit          err;
      int          cyc;
   } exp_t;

   exp_t        sb[$];
   int          total = 0;
   int          bad = 0;
   int          cycle_cnt = 0;
   int          forced_n = -1;
   bit          forced_rd_en = 1'b0;
   logic [63:0] forced_rd = 64'h0;

   // reference-model state
   bit          last_owner, prev_mreq, g_win;
   int          g_c, g_n;
   logic [63:0] g_rd, exp_addr, exp_wdata, exp_i_rd, exp_d_rd;
   bit          exp_we;
   logic [1:0]  exp_size;
   bit          snap_i, snap_d, snap_we;
   logic [63:0] snap_iaddr, snap_daddr, snap_wdata;
   logic [1:0]  snap_size;

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   always @(posedge clock) cycle_cnt <= cycle_cnt + 1;

   task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%h want=%h (cycle %0d)", nm, got, exp, cycle_cnt);
      end
   endtask

   // Grant monitor + memory model: predicts the winner from the sampled requests.
   initial begin : grant_mon
      int pick;
      forever begin
         @(negedge clock);
         if (reset) begin
            g_c = 0; last_owner = 1'b0; prev_mreq = 1'b0; mem_ready = 1'b0;
         end else begin
            if (mem_req && !prev_mreq) begin
               chk("grant_has_req", {63'h0, snap_i | snap_d}, 64'h1);
               g_win      = (snap_i && snap_d) ? ~last_owner : snap_d;
               last_owner = g_win;
               exp_addr   = g_win ? snap_daddr : snap_iaddr;
               exp_we     = g_win ? snap_we : 1'b0;
               exp_size   = g_win ? snap_size : 2'b10;
               exp_wdata  = snap_wdata;
               chk("grant_owner", {63'h0, owner}, {63'h0, g_win});
               chk("grant_addr", mem_addr, exp_addr);
               chk("grant_we", {63'h0, mem_we}, {63'h0, exp_we});
               chk("grant_size", {62'h0, mem_size}, {62'h0, exp_size});
               if (g_win) chk("grant_wdata", mem_wdata, exp_wdata);
               if (forced_n >= 0) g_n = forced_n;
               else begin
                  pick = $urandom_range(0, 8);
                  g_n = (pick < 5) ? pick : (pick == 5 ? 14 : (pick == 6 ? 15 : (pick == 7 ? 16 : 20)));
               end
               g_rd = forced_rd_en ? forced_rd : {$urandom, $urandom};
               sb.push_back('{port: g_win, rdata: (g_n > TO) ? 64'h0 : g_rd, err: (g_n > TO),
                              cyc: cycle_cnt + ((g_n > TO) ? TO + 1 : g_n + 1)});
               g_c = 0;
            end else if (mem_req) begin
               chk("hold_addr", mem_addr, exp_addr);
               chk("hold_we", {63'h0, mem_we}, {63'h0, exp_we});
               chk("hold_size", {62'h0, mem_size}, {62'h0, exp_size});
               if (g_win) chk("hold_wdata", mem_wdata, exp_wdata);
            end
            if (mem_req) begin
               g_c++;
               mem_ready = (g_n <= TO) && (g_c == g_n + 1);
               mem_rdata = mem_ready ? g_rd : {$urandom, $urandom};
            end else begin
               mem_ready = 1'($urandom_range(0, 1));
               mem_rdata = {$urandom, $urandom};
            end
            prev_mreq = mem_req;
         end
         snap_i = i_req; snap_d = d_req; snap_we = d_we; snap_size = d_size;
         snap_iaddr = i_addr; snap_daddr = d_addr; snap_wdata = d_wdata;
      end
   end

   // Ack monitor: pops the scoreboard whenever the DUT acknowledges.
   initial begin : ack_mon
      exp_t e;
      forever begin
         @(negedge clock);
         if (reset) begin
            sb.delete(); exp_i_rd = 64'h0; exp_d_rd = 64'h0;
         end else begin
            if (i_ack && d_ack) chk("double_ack", 64'h1, 64'h0);
            if (sb.size() > 0 && cycle_cnt > sb[0].cyc && !(i_ack || d_ack)) begin
               chk("ack_missing", 64'h0, 64'h1);
               void'(sb.pop_front());
            end
            if (i_ack || d_ack) begin
               if (sb.size() == 0) chk("ack_without_grant", 64'h1, 64'h0);
               else begin
                  e = sb.pop_front();
                  chk("ack_port", {63'h0, d_ack}, {63'h0, e.port});
                  chk("ack_cycle", 64'(cycle_cnt), 64'(e.cyc));
                  chk("ack_bus_err", {63'h0, bus_err}, {63'h0, e.err});
                  chk("ack_mem_req_low", {63'h0, mem_req}, 64'h0);
                  if (e.port) exp_d_rd = e.rdata; else exp_i_rd = e.rdata;
               end
            end else begin
               chk("bus_err_idle", {63'h0, bus_err}, 64'h0);
            end
            chk("i_rdata", i_rdata, exp_i_rd);
            chk("d_rdata", d_rdata, exp_d_rd);
         end
      end
   end

   task automatic issue(input bit port, input logic [63:0] addr, input bit we, input logic [1:0] size,
                        input logic [63:0] wdata, output int lat, output bit err);
      int t0;
      @(posedge clock); #1;
      if (port) begin d_req = 1'b1; d_we = we; d_size = size; d_addr = addr; d_wdata = wdata; end
      else begin i_req = 1'b1; i_addr = addr; end
      t0 = cycle_cnt; lat = -1; err = 1'b0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clock);
         if ((port && d_ack) || (!port && i_ack)) begin
            lat = cycle_cnt - t0; err = bus_err; break;
         end
      end
      @(posedge clock); #1;
      if (port) d_req = 1'b0; else i_req = 1'b0;
   endtask

   task automatic drive_fields(input bit port);
      if (port) begin
         d_req = 1'b1; d_we = 1'($urandom_range(0, 1)); d_size = 2'($urandom_range(0, 3));
         d_addr = {$urandom, $urandom}; d_wdata = {$urandom, $urandom};
      end else begin
         i_req = 1'b1; i_addr = {$urandom, $urandom};
      end
   endtask

   task automatic rand_req(input bit port, input int count);
      int g;
      bit got;
      for (int t = 0; t < count; t++) begin
         g = $urandom_range(0, 3);
         if (g != 0) begin repeat (g) @(posedge clock); #1; end
         drive_fields(port);
         got = 1'b0;
         for (int k = 0; k < 64; k++) begin
            @(negedge clock);
            if (port ? d_ack : i_ack) got = 1'b1;
            @(posedge clock); #1;
            if (got) break;
            if ($urandom_range(0, 2) == 0) drive_fields(port);
         end
         chk("rand_ack_seen", {63'h0, got}, 64'h1);
         if (port) d_req = 1'b0; else i_req = 1'b0;
      end
   endtask

   initial begin : watchdog
      #400000;
      $display("FAIL watchdog: simulation did not finish, got=timeout want=finish");
      $fatal(1, "watchdog");
   end

   initial begin : main
      int lat, nacks, t0;
      bit err, saw;
      bit seq[4];
      int acyc[4];
      logic [63:0] cap;
      reset = 1'b1; mem_ready = 1'b0; mem_rdata = 64'h0;
      i_req = 1'b1; i_addr = 64'h500;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b11; d_addr = 64'h600; d_wdata = 64'h0;
      forced_n = 0;
      repeat (3) @(posedge clock);
      #1;
      chk("rst_mem_req", {63'h0, mem_req}, 64'h0);
      chk("rst_mem_we", {63'h0, mem_we}, 64'h0);
      chk("rst_mem_size", {62'h0, mem_size}, 64'h0);
      chk("rst_mem_addr", mem_addr, 64'h0);
      chk("rst_mem_wdata", mem_wdata, 64'h0);
      chk("rst_acks", {62'h0, i_ack, d_ack}, 64'h0);
      chk("rst_bus_err", {63'h0, bus_err}, 64'h0);
      chk("rst_owner", {63'h0, owner}, 64'h0);
      chk("rst_i_rdata", i_rdata, 64'h0);
      chk("rst_d_rdata", d_rdata, 64'h0);

      // collision fairness straight out of reset
      reset = 1'b0;
      nacks = 0;
      for (int k = 0; k < 40 && nacks < 4; k++) begin
         @(negedge clock);
         if (i_ack || d_ack) begin seq[nacks] = d_ack; acyc[nacks] = cycle_cnt; nacks++; end
      end
      @(posedge clock); #1;
      i_req = 1'b0; d_req = 1'b0;
      chk("coll_acks", 64'(nacks), 64'd4);
      for (int k = 0; k < 4; k++) chk("coll_order", {63'h0, seq[k]}, {63'h0, (k % 2) == 0});
      for (int k = 1; k < 4; k++) chk("coll_period", 64'(acyc[k] - acyc[k-1]), 64'd3);

      forced_rd_en = 1'b1; forced_rd = 64'h8B020020;
      issue(1'b0, 64'h100, 1'b0, 2'b10, 64'h0, lat, err);
      chk("fetch_latency", 64'(lat), 64'd2);
      chk("fetch_rdata", i_rdata, 64'h8B020020);
      forced_rd_en = 1'b0;

      forced_n = 4;
      issue(1'b1, 64'h2000, 1'b1, 2'b11, 64'hDEADBEEF, lat, err);
      chk("store_latency", 64'(lat), 64'd6);
      chk("store_bus_err", {63'h0, err}, 64'h0);

      forced_n = 99;
      issue(1'b1, 64'h3000, 1'b0, 2'b11, 64'h0, lat, err);
      chk("timeout_latency", 64'(lat), 64'd17);
      chk("timeout_bus_err", {63'h0, err}, 64'h1);
      chk("timeout_rdata", d_rdata, 64'h0);
      forced_n = 0;
      issue(1'b0, 64'h104, 1'b0, 2'b10, 64'h0, lat, err);
      chk("post_timeout_latency", 64'(lat), 64'd2);
      chk("post_timeout_err", {63'h0, err}, 64'h0);

      // reset two cycles into a fetch
      forced_n = 99;
      @(posedge clock); #1;
      i_req = 1'b1; i_addr = 64'h300;
      @(posedge clock);
      @(posedge clock); #3;
      reset = 1'b1; #1;
      chk("rst_async_mem_req", {63'h0, mem_req}, 64'h0);
      forced_n = 0; saw = 1'b0;
      repeat (3) begin @(negedge clock); if (i_ack) saw = 1'b1; end
      @(posedge clock); #1;
      reset = 1'b0; t0 = cycle_cnt; lat = -1; cap = 64'h0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (mem_req) cap = mem_addr;
         if (i_ack) begin lat = cycle_cnt - t0; break; end
         if (saw == 1'b0 && d_ack) saw = 1'b1;
      end
      @(posedge clock); #1;
      i_req = 1'b0;
      chk("rst_no_ack", {63'h0, saw}, 64'h0);
      chk("rst_regrant_latency", 64'(lat), 64'd2);
      chk("rst_regrant_addr", cap, 64'h300);

      // requester input change during ACCESS is ignored
      forced_n = 3;
      @(posedge clock); #1;
      d_req = 1'b1; d_we = 1'b0; d_size = 2'b11; d_addr = 64'h40; t0 = cycle_cnt; lat = -1;
      @(posedge clock); #1;
      d_addr = 64'h80;
      for (int k = 0; k < 20; k++) begin
         @(negedge clock);
         if (mem_req) chk("change_addr_held", mem_addr, 64'h40);
         if (d_ack) begin lat = cycle_cnt - t0; break; end
      end
      @(posedge clock); #1;
      d_req = 1'b0;
      chk("change_latency", 64'(lat), 64'd5);

      // randomized concurrent traffic
      forced_n = -1;
      fork
         rand_req(1'b0, 150);
         rand_req(1'b1, 150);
      join
      repeat (5) @(posedge clock);
      chk("sb_drained", 64'(sb.size()), 64'd0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares the single 64-bit memory port between two requesters of the LEGv8 multicycle datapath: instruction fetch (IF state, port I) and data load/store (LDUR/STUR execute, port D).
- Sequences each access through a grant / wait / acknowledge handshake.
- Enforces round-robin fairness and a bounded wait with a bus-error timeout.
- The control unit stalls its state register until the relevant ack arrives.

Parameters:
- ADDR_W, 64, address width for both requesters and the memory port.
- DATA_W, 64, data width for both requesters and the memory port.
- TIMEOUT, 15, maximum ACCESS cycles without mem_ready before an error response; legal range 1..255.

Ports:
- clock  input  1  single clock; all state updates on the rising edge.
- reset  input  1  asynchronous, active-high; clears all state immediately.
- i_req  input  1  instruction-fetch request; held high until i_ack.
- i_addr  input  ADDR_W  fetch address (PC); always a read, size 2'b10.
- i_ack  output  1  one-cycle pulse; i_rdata valid.
- i_rdata  output  DATA_W  fetched word, zero-extended.
- d_req  input  1  data request; held high until d_ack.
- d_we  input  1  1 = store, 0 = load.
- d_size  input  2  access size code, passed through.
- d_addr  input  ADDR_W  data address.
- d_wdata  input  DATA_W  store data.
- d_ack  output  1  one-cycle pulse; d_rdata valid.
- d_rdata  output  DATA_W  load data.
- mem_req  output  1  memory access active.
- mem_we  output  1  memory write enable.
- mem_size  output  2  access size.
- mem_addr  output  ADDR_W  memory address.
- mem_wdata  output  DATA_W  memory write data.
- mem_ready  input  1  memory completes the access this cycle; mem_rdata valid.
- mem_rdata  input  DATA_W  memory read data.
- bus_err  output  1  one-cycle pulse coincident with the ack of a timed-out access.
- owner  output  1  current or last grant: 0 = I, 1 = D.

Behaviour:
- States: IDLE, ACCESS, RESP.
- Reset values: state = IDLE; all outputs 0, including rdata registers and owner; wait counter = 0.
- IDLE:
  - No request: stay in IDLE.
  - Exactly one request: grant it.
  - Both requests: grant the port that is not owner (round-robin). owner = 0 after reset, so D wins the first collision.
  - On grant: latch addr, we, size and wdata into request registers (I forces we = 0, size = 2'b10), set owner, clear counter, go to ACCESS.
- ACCESS:
  - mem_req = 1; mem_* outputs driven from the latched registers. Requester inputs are ignored, and changing them mid-access has no effect.
  - mem_ready = 1: capture mem_rdata into the owner's rdata register, go to RESP.
  - Otherwise increment the counter. When the counter reaches TIMEOUT with mem_ready still low: rdata = 0, set the error flag, go to RESP.
- RESP:
  - mem_req = 0; the owner's ack = 1 for exactly this cycle; bus_err = error flag.
  - Next state is IDLE; error flag clears.
  - The requester drops req in the cycle after it sees ack, so IDLE never regrants the same transaction.
- Latency: req sampled in IDLE at cycle 0 → mem_req at cycle 1 → ack at cycle n+2, where n = number of cycles mem_ready stays low. Minimum req-to-ack latency is 2 cycles. Back-to-back accesses have a 3-cycle period.
- Stores: the d_rdata register is still loaded from mem_rdata; its value is don't-care to the user but deterministic.
- rdata registers hold their value until the next completion on the same port.
- Never more than one ack per cycle; never an ack without a preceding grant.
- mem_ready while not in ACCESS is ignored.
- Reset mid-access: immediate return to IDLE, mem_req = 0, no ack issued. Any pending req is re-arbitrated after reset releases.
- Counter is 8 bits and saturates; no wrap is possible because TIMEOUT ≤ 255.

Test Plan:
- Single fetch: i_req = 1, i_addr = 0x100, mem_ready = 1 in the first ACCESS cycle, mem_rdata = 0x8B020020 → mem_addr = 0x100 and mem_we = 0 at cycle 1; i_ack = 1 and i_rdata = 0x8B020020 at cycle 2; IDLE at cycle 3.
- Store with wait states: d_req = 1, d_we = 1, d_addr = 0x2000, d_wdata = 0xDEADBEEF, d_size = 3, mem_ready low for 4 cycles → mem_req held 5 cycles with stable mem_* values; d_ack at cycle 6; bus_err = 0.
- Collision fairness: i_req and d_req both held continuously from reset, re-asserted after each ack → grant sequence D, I, D, I; each ack 3 cycles apart with mem_ready = 1.
- Timeout: d_req, mem_ready tied 0, TIMEOUT = 15 → d_ack and bus_err pulse together at cycle 17; d_rdata = 0; next i_req is served normally.
- Reset mid-ACCESS: assert reset 2 cycles into a fetch → mem_req drops asynchronously and no i_ack occurs. After reset release with i_req still high → fresh grant, mem_addr correct.
- Input change during ACCESS: change d_addr from 0x40 to 0x80 after grant → mem_addr remains 0x40 until RESP.
